add_test_sequencer: RTL



---
 rtl/add_test_sequencer_pkg.sv | 16 +
 rtl/add_test_sequencer_delay_line.sv | 26 ++
 rtl/add_test_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/add_test_sequencer_pkg.sv
// add_test_sequencer_pkg: CSR map, STATUS bit positions and sequencer states
package add_test_sequencer_pkg;
  localparam logic [2:0] CSR_CTRL    = 3'd0;
  localparam logic [2:0] CSR_STATUS  = 3'd1;
  localparam logic [2:0] CSR_START   = 3'd2;
  localparam logic [2:0] CSR_COUNT   = 3'd3;
  localparam logic [2:0] CSR_LATENCY = 3'd4;
  localparam logic [2:0] CSR_CYCLES  = 3'd5;
  localparam logic [2:0] CSR_RSVD    = 3'd6;
  localparam logic [2:0] CSR_ID      = 3'd7;
  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_LOCK_ERR = 2;
  localparam int STAT_PLL_LOCK = 3;
  typedef enum logic [2:0] {IDLE, WAIT_LOCK, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/add_test_sequencer_delay_line.sv
// seq_addr_delay_line: flushable shift register with a runtime-selected output tap
module seq_addr_delay_line #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                       pll_clock,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  input  logic [$clog2(DEPTH+1)-1:0] lat,
  output logic [WIDTH-1:0]           dout
);
  localparam int LW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] stage [1:DEPTH];
  always_ff @(posedge pll_clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 1; i <= DEPTH; i++) stage[i] <= '0;
    end else if (flush) begin
      for (int i = 1; i <= DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[1] <= din;
      for (int i = 2; i <= DEPTH; i++) stage[i] <= stage[i-1];
    end
  end
  assign dout = lat == '0 ? din : lat > LW'(DEPTH) ? '0 : stage[lat];
endmodule

// File: rtl/add_test_sequencer.sv
// add_test_sequencer: CSR-programmed operand read burst with latency-aligned result writes
module add_test_sequencer
  import add_test_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_LAT    = 8,
  parameter int ID         = 8
) (
  input  logic                  pll_clock,
  input  logic                  resetn,
  input  logic                  read,
  input  logic                  write,
  input  logic [2:0]            address,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic                  pll_lock,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic                  we,
  output logic                  busy
);
  localparam int LW = $clog2(MAX_LAT+1);
  localparam int IW = ADDR_WIDTH + 1;
  state_t state, nxt;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [IW-1:0] count, idx, idx_nxt;
  logic [LW-1:0] lat, lat_wr;
  logic [31:0] cycles, status, rd_data;
  logic done, lock_err, set_done;
  logic wr_ctrl, wr_status, go, abort, active, lock_drop, flush;
  assign wr_ctrl   = write && address == CSR_CTRL;
  assign wr_status = write && address == CSR_STATUS;
  assign abort     = wr_ctrl && writedata[1];
  assign go        = wr_ctrl && writedata[0] && !writedata[1] && (state == IDLE || state == DONE);
  assign active    = state == RUN || state == DRAIN;
  assign busy      = active || state == WAIT_LOCK;
  assign lock_drop = active && !pll_lock;
  assign flush     = abort || lock_drop;
  assign r_en      = state == RUN;
  assign r_addr    = start_addr + idx[ADDR_WIDTH-1:0];
  assign lat_wr    = writedata == 32'd0 ? LW'(1) : writedata > 32'(MAX_LAT) ? LW'(MAX_LAT) : writedata[LW-1:0];
  always_comb begin
    nxt = state;
    idx_nxt = idx;
    set_done = 1'b0;
    case (state)
      IDLE, DONE: if (go) begin
        nxt = count == '0 ? DONE : WAIT_LOCK;
        set_done = count == '0;
        idx_nxt = '0;
      end
      WAIT_LOCK: nxt = pll_lock ? RUN : WAIT_LOCK;
      RUN: begin
        nxt = idx == count - 1'b1 ? DRAIN : RUN;
        idx_nxt = idx == count - 1'b1 ? IW'(1) : idx + 1'b1;
      end
      DRAIN: begin
        nxt = idx == IW'(lat) ? DONE : DRAIN;
        set_done = idx == IW'(lat);
        idx_nxt = idx + 1'b1;
      end
      default: nxt = IDLE;
    endcase
    if (flush) begin
      nxt = IDLE;
      set_done = 1'b0;
    end
  end
  always_ff @(posedge pll_clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      idx <= '0;
      start_addr <= '0;
      count <= '0;
      lat <= LW'(MAX_LAT);
      cycles <= '0;
      done <= 1'b0;
      lock_err <= 1'b0;
      readdata <= '0;
    end else begin
      state <= nxt;
      idx <= idx_nxt;
      cycles <= go ? '0 : (active && cycles != '1) ? cycles + 1'b1 : cycles;
      done <= set_done || (done && !go && !(wr_status && writedata[STAT_DONE]));
      lock_err <= lock_drop || (lock_err && !go && !(wr_status && writedata[STAT_LOCK_ERR]));
      if (write && !busy && address == CSR_START) start_addr <= writedata[ADDR_WIDTH-1:0];
      if (write && !busy && address == CSR_COUNT) count <= writedata[ADDR_WIDTH:0];
      if (write && !busy && address == CSR_LATENCY) lat <= lat_wr;
      if (read) readdata <= rd_data;
    end
  end
  always_comb begin
    status = '0;
    status[STAT_BUSY] = busy;
    status[STAT_DONE] = done;
    status[STAT_LOCK_ERR] = lock_err;
    status[STAT_PLL_LOCK] = pll_lock;
  end
  assign rd_data = address == CSR_STATUS  ? status
                 : address == CSR_START   ? 32'(start_addr)
                 : address == CSR_COUNT   ? 32'(count)
                 : address == CSR_LATENCY ? 32'(lat)
                 : address == CSR_CYCLES  ? cycles
                 : address == CSR_ID      ? 32'(ID)
                 : address == CSR_RSVD    ? 32'd0 : 32'd0;
  seq_addr_delay_line #(.WIDTH(ADDR_WIDTH + 1), .DEPTH(MAX_LAT)) u_delay (
    .pll_clock(pll_clock),
    .resetn(resetn),
    .flush(flush),
    .din({r_en, r_addr}),
    .lat(lat),
    .dout({we, w_addr})
  );
endmodule
